// File: rtl/mmu_pkg.sv
// Shared types and constants for the MMU3 sequencer.
package mmu_pkg;
  localparam int SIZE_DEF      = 256;
  localparam int BIT_WIDTH_DEF = 32;
  localparam int RD_LAT        = 2;  // read strobe -> registered onto mmu_* bus

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_e;
endpackage

// File: rtl/mmu_seq_ctrl_if.sv
// Memory-read and MMU-facing bus of the sequencer; master = sequencer side.
interface mmu_seq_ctrl_if import mmu_pkg::*; #(
  parameter int SIZE      = SIZE_DEF,
  parameter int BIT_WIDTH = BIT_WIDTH_DEF,
  parameter int ROW_AW    = 14
);
  localparam int VW  = SIZE * BIT_WIDTH;
  localparam int WAW = $clog2(SIZE);

  logic              wt_rd_en;
  logic [WAW-1:0]    wt_rd_addr;
  logic [VW-1:0]     wt_rd_data;
  logic              act_rd_en;
  logic [ROW_AW-1:0] act_rd_addr;
  logic [VW-1:0]     act_rd_data;
  logic              mmu_control;
  logic [VW-1:0]     mmu_wt_arr;
  logic [VW-1:0]     mmu_data_arr;
  logic              result_valid;
  logic [ROW_AW-1:0] result_row;

  modport master (
    output wt_rd_en, wt_rd_addr, act_rd_en, act_rd_addr,
    output mmu_control, mmu_wt_arr, mmu_data_arr, result_valid, result_row,
    input  wt_rd_data, act_rd_data
  );
  modport slave (
    input  wt_rd_en, wt_rd_addr, act_rd_en, act_rd_addr,
    input  mmu_control, mmu_wt_arr, mmu_data_arr, result_valid, result_row,
    output wt_rd_data, act_rd_data
  );
endinterface

// File: rtl/mmu_seq_delay.sv
// Single-bit delay line of DEPTH flops with synchronous clear.
module mmu_seq_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] vld_pipe_q, vld_pipe_d;

  always_comb vld_pipe_d = DEPTH'({vld_pipe_q, d});

  always_ff @(posedge clk) begin
    if (rst) vld_pipe_q <= '0;
    else     vld_pipe_q <= vld_pipe_d;
  end

  assign q = vld_pipe_q[DEPTH-1];
endmodule

// File: rtl/mmu_seq_ctrl.sv
// MMU3 sequencer: weight load (last column first), activation stream, drain, done.
// Optional MMU_SEQ_PERF_CNT_EN adds a saturating busy-cycle counter output.
module mmu_seq_ctrl import mmu_pkg::*; #(
  parameter int SIZE         = SIZE_DEF,
  parameter int BIT_WIDTH    = BIT_WIDTH_DEF,
  parameter int MAX_ROWS     = 13000,
  parameter int ROW_AW       = $clog2(MAX_ROWS + 1),
  parameter int MMU_LATENCY  = 2 * SIZE,
  parameter int DRAIN_CYCLES = MMU_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROW_AW-1:0] num_rows,
  output logic              busy,
  output logic              done,
`ifdef MMU_SEQ_PERF_CNT_EN
  output logic [31:0]       cycle_count,
`endif
  mmu_seq_ctrl_if.master    bus
);
  localparam int VW  = SIZE * BIT_WIDTH;
  localparam int WAW = $clog2(SIZE);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  if (DRAIN_CYCLES < MMU_LATENCY) begin : g_drain_chk
    $error("DRAIN_CYCLES must be >= MMU_LATENCY");
  end
  if (MMU_LATENCY < 2) begin : g_lat_chk
    $error("MMU_LATENCY must be >= 2");
  end

  state_e            state_q, state_d;
  logic [ROW_AW-1:0] rows_q, rows_d, act_addr_q, act_addr_d;
  logic [WAW-1:0]    wt_addr_q, wt_addr_d;
  logic [DCW-1:0]    drain_q, drain_d;
  logic              wt_en_q, wt_en_d, act_en_q, act_en_d, done_q, done_d;
  logic              accept;

  assign accept = (state_q == IDLE) && start;

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    wt_addr_d  = wt_addr_q;
    wt_en_d    = 1'b0;
    act_addr_d = '0;
    act_en_d   = 1'b0;
    drain_d    = drain_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d   = LOAD_W;
        rows_d    = (num_rows > ROW_AW'(MAX_ROWS)) ? ROW_AW'(MAX_ROWS) : num_rows;
        wt_en_d   = 1'b1;
        wt_addr_d = WAW'(SIZE - 1);
      end
      LOAD_W: if (wt_addr_q == '0) begin
        // An empty job skips the drain: nothing is in flight through the array.
        if (rows_q != '0) begin
          state_d  = STREAM;
          act_en_d = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end else begin
        wt_en_d   = 1'b1;
        wt_addr_d = wt_addr_q - WAW'(1);
      end
      STREAM: if (act_addr_q == rows_q - ROW_AW'(1)) begin
        state_d = DRAIN;
        drain_d = '0;
      end else begin
        act_en_d   = 1'b1;
        act_addr_d = act_addr_q + ROW_AW'(1);
      end
      DRAIN: if (drain_q == DCW'(DRAIN_CYCLES - 1)) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        drain_d = drain_q + DCW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rows_q     <= '0;
      wt_addr_q  <= '0;
      wt_en_q    <= 1'b0;
      act_addr_q <= '0;
      act_en_q   <= 1'b0;
      drain_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      wt_addr_q  <= wt_addr_d;
      wt_en_q    <= wt_en_d;
      act_addr_q <= act_addr_d;
      act_en_q   <= act_en_d;
      drain_q    <= drain_d;
      done_q     <= done_d;
    end
  end

  // Busy covers the accepting cycle itself, so it is the only combinational output.
  assign busy = !rst && ((state_q != IDLE) || start);
  assign done = done_q;
  assign bus.wt_rd_en    = wt_en_q;
  assign bus.wt_rd_addr  = wt_addr_q;
  assign bus.act_rd_en   = act_en_q;
  assign bus.act_rd_addr = act_addr_q;

  // Datapath: strobes delayed to line up with memory data, then registered onto the MMU.
  logic              wt_en_d1, act_en_d1, rv_pre;
  logic              ctrl_q, ctrl_d, act_vld_q, act_vld_d, rv_q, rv_d;
  logic [VW-1:0]     wt_arr_q, wt_arr_d, data_q, data_d;
  logic [ROW_AW-1:0] row_q, row_d;

  mmu_seq_delay #(.DEPTH(RD_LAT - 1))      u_wt_dly  (.clk(clk), .rst(rst), .d(wt_en_q),   .q(wt_en_d1));
  mmu_seq_delay #(.DEPTH(RD_LAT - 1))      u_act_dly (.clk(clk), .rst(rst), .d(act_en_q),  .q(act_en_d1));
  mmu_seq_delay #(.DEPTH(MMU_LATENCY - 1)) u_res_dly (.clk(clk), .rst(rst), .d(act_vld_q), .q(rv_pre));

  always_comb begin
    ctrl_d    = wt_en_d1;
    wt_arr_d  = wt_en_d1 ? bus.wt_rd_data : wt_arr_q;
    act_vld_d = act_en_d1;
    data_d    = act_en_d1 ? bus.act_rd_data : '0;
    rv_d      = rv_pre;
    row_d     = rv_pre ? (rv_q ? row_q + ROW_AW'(1) : '0) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= 1'b0;
      wt_arr_q  <= '0;
      act_vld_q <= 1'b0;
      data_q    <= '0;
      rv_q      <= 1'b0;
      row_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      wt_arr_q  <= wt_arr_d;
      act_vld_q <= act_vld_d;
      data_q    <= data_d;
      rv_q      <= rv_d;
      row_q     <= row_d;
    end
  end

  assign bus.mmu_control  = ctrl_q;
  assign bus.mmu_wt_arr   = wt_arr_q;
  assign bus.mmu_data_arr = data_q;
  assign bus.result_valid = rv_q;
  assign bus.result_row   = row_q;

`ifdef MMU_SEQ_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (accept)                      cyc_d = 32'd1;
    else if (busy && (cyc_q != '1))  cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end

  assign cycle_count = cyc_q;
`endif
endmodule
